// File: rtl/rc_capture_array.sv
// rc_capture_array: N-channel RC receiver pulse capture.
//
// Each PWM pin is synchronised, its high time is measured in microseconds,
// glitches and over-long pulses are rejected, and accepted widths are clamped
// and scaled to a VAL_WIDTH-bit value. A per-channel timeout flags channels that
// have not delivered an accepted pulse within TIMEOUT_US.
//
// Ports:
//   sys_clk      in   system clock
//   reset        in   synchronous, active-high reset
//   pwm_in       in   [NUM_CH] asynchronous PWM pins, bit i = channel i
//   ch_val       out  [NUM_CH*VAL_WIDTH] scaled values, channel i at [i*VAL_WIDTH +: VAL_WIDTH]
//   ch_update    out  [NUM_CH] one-cycle pulse when a channel's ch_val slice is written
//   ch_valid     out  [NUM_CH] channel has an accepted pulse within TIMEOUT_US
//   signal_lost  out  OR of ~ch_valid
//
// Build option: define RC_FAILSAFE_EN to force a failsafe value (channel 0 -> 0,
// others -> midscale) into ch_val, with a ch_update pulse, when ch_valid falls.

module rc_capture_array #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned VAL_WIDTH  = 8,
    parameter int unsigned US_DIV     = 38,
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned MAX_US     = 2000,
    parameter int unsigned TIMEOUT_US = 25000
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             pwm_in,
    output logic [NUM_CH*VAL_WIDTH-1:0]   ch_val,
    output logic [NUM_CH-1:0]             ch_update,
    output logic [NUM_CH-1:0]             ch_valid,
    output logic                          signal_lost
);

    localparam int unsigned DIV_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int unsigned W_SAT  = 2 * MAX_US + 1;
    localparam int unsigned W_W    = $clog2(W_SAT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_US + 1);
    localparam int unsigned SCALE  = ((2 ** VAL_WIDTH - 1) << 10) / (MAX_US - MIN_US);
    localparam int unsigned PROD_W = W_W + $clog2(SCALE + 1);

    localparam logic [W_W-1:0]   W_MIN    = W_W'(MIN_US);
    localparam logic [W_W-1:0]   W_MAX    = W_W'(MAX_US);
    localparam logic [W_W-1:0]   W_LO     = W_W'(MIN_US / 2);
    localparam logic [W_W-1:0]   W_HI     = W_W'(2 * MAX_US);
    localparam logic [W_W-1:0]   W_SAT_V  = W_W'(W_SAT);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_US);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(US_DIV - 1);

    typedef enum logic [1:0] {
        StArm,
        StWaitRise,
        StMeasure,
        StEval
    } state_e;

    // Shared microsecond tick.
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic                 s1_q, s2_q, s3_q;
        logic                 rise, fall;
        state_e               state_q, state_d;
        logic [W_W-1:0]       w_q, w_d;
        logic [TO_W-1:0]      to_q, to_d;
        logic                 seen_q, seen_d;
        logic                 valid_q, valid_d;
        logic                 upd_q, upd_d;
        logic [VAL_WIDTH-1:0] val_q, val_d;
        logic [VAL_WIDTH-1:0] scaled;
        logic [PROD_W-1:0]    prod;
        logic                 accept;

`ifdef RC_FAILSAFE_EN
        localparam logic [VAL_WIDTH-1:0] FS_MID = {1'b1, {(VAL_WIDTH-1){1'b0}}};
        localparam logic [VAL_WIDTH-1:0] FS_VAL = (i == 0) ? '0 : FS_MID;
`endif

        // Synchroniser and edge register reset high: a pin that is high at
        // reset release then produces no rising edge and must first be seen low.
        always_ff @(posedge sys_clk) begin
            if (reset) begin
                s1_q <= 1'b1;
                s2_q <= 1'b1;
                s3_q <= 1'b1;
            end else begin
                s1_q <= pwm_in[i];
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end

        assign rise = s2_q & ~s3_q;
        assign fall = ~s2_q & s3_q;

        always_comb begin
            prod   = '0;
            scaled = '0;
            if (w_q <= W_MIN) begin
                scaled = '0;
            end else if (w_q >= W_MAX) begin
                scaled = '1;
            end else begin
                prod   = PROD_W'(w_q - W_MIN) * PROD_W'(SCALE);
                scaled = VAL_WIDTH'(prod >> 10);
            end
        end

        always_comb begin
            state_d = state_q;
            w_d     = w_q;
            accept  = 1'b0;
            unique case (state_q)
                StArm: begin
                    if (!s2_q) state_d = StWaitRise;
                end
                StWaitRise: begin
                    if (rise) begin
                        w_d     = '0;
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    if (fall) begin
                        state_d = StEval;
                    end else if (w_q == W_SAT_V) begin
                        // Stuck-high pin: drop the pulse and wait for a low level.
                        state_d = StArm;
                    end else if (tick) begin
                        w_d = w_q + 1'b1;
                    end
                end
                StEval: begin
                    accept  = (w_q >= W_LO) && (w_q <= W_HI);
                    state_d = StWaitRise;
                end
                default: state_d = StArm;
            endcase
        end

        always_comb begin
            val_d  = val_q;
            upd_d  = 1'b0;
            seen_d = seen_q | accept;
            if (accept)                      to_d = '0;
            else if (tick && to_q != TO_MAX) to_d = to_q + 1'b1;
            else                             to_d = to_q;
            // An accept clears the counter, so it always wins over expiry.
            valid_d = seen_d && (to_d < TO_MAX);
            if (accept) begin
                val_d = scaled;
                upd_d = 1'b1;
            end
`ifdef RC_FAILSAFE_EN
            else if (valid_q && !valid_d) begin
                val_d = FS_VAL;
                upd_d = 1'b1;
            end
`endif
        end

        always_ff @(posedge sys_clk) begin
            if (reset) begin
                state_q <= StArm;
                w_q     <= '0;
                to_q    <= '0;
                seen_q  <= 1'b0;
                valid_q <= 1'b0;
                upd_q   <= 1'b0;
                val_q   <= '0;
            end else begin
                state_q <= state_d;
                w_q     <= w_d;
                to_q    <= to_d;
                seen_q  <= seen_d;
                valid_q <= valid_d;
                upd_q   <= upd_d;
                val_q   <= val_d;
            end
        end

        assign ch_val[i*VAL_WIDTH +: VAL_WIDTH] = val_q;
        assign ch_update[i]                     = upd_q;
        assign ch_valid[i]                      = valid_q;
    end

    assign signal_lost = |(~ch_valid);

endmodule

// File: tb/tb_rc_capture_array.sv
module tb_rc_capture_array;

    localparam int unsigned NCH = 4;
    localparam int unsigned VW  = 8;
    localparam int unsigned DIV = 2;
    localparam int unsigned TMO = 5000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      pwm = '0;
    logic [NCH*VW-1:0]   ch_val;
    logic [NCH-1:0]      ch_update;
    logic [NCH-1:0]      ch_valid;
    logic                signal_lost;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_up2 = 0;

    rc_capture_array #(
        .NUM_CH     (NCH),
        .VAL_WIDTH  (VW),
        .US_DIV     (DIV),
        .MIN_US     (1000),
        .MAX_US     (2000),
        .TIMEOUT_US (TMO)
    ) dut (
        .sys_clk     (clk),
        .reset       (rst),
        .pwm_in      (pwm),
        .ch_val      (ch_val),
        .ch_update   (ch_update),
        .ch_valid    (ch_valid),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ch_update[2]) last_up2 = cyc;

    typedef struct {
        int unsigned w [4];
        logic [3:0]  exp_upd;
        logic [3:0]  exp_valid;
        int          lo [4];
        int          hi [4];
    } vec_t;

    task automatic check(input bit ok, input string name, input int act, input int lo,
                         input int hi);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        check(act >= lo && act <= hi, name, act, lo, hi);
    endtask

    function automatic int val_of(input int c);
        return int'(ch_val[c*VW +: VW]);
    endfunction

    function automatic vec_t mk(input int w0, input int w1, input int w2, input int w3,
                                input logic [3:0] u, input logic [3:0] vld,
                                input int l0, input int h0, input int l1, input int h1,
                                input int l2, input int h2, input int l3, input int h3);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.exp_upd = u;
        v.exp_valid = vld;
        v.lo[0] = l0; v.lo[1] = l1; v.lo[2] = l2; v.lo[3] = l3;
        v.hi[0] = h0; v.hi[1] = h1; v.hi[2] = h2; v.hi[3] = h3;
        return v;
    endfunction

    // Pulses are staggered so that every active channel falls in the same cycle.
    task automatic run_vec(input vec_t v, input string name);
        int unsigned maxc = 0;
        int unsigned wc [4];
        int          lat = -1;
        logic [3:0]  upd_at = '0;
        for (int c = 0; c < 4; c++) begin
            wc[c] = v.w[c] * DIV;
            if (wc[c] > maxc) maxc = wc[c];
        end
        for (int t = 0; t < int'(maxc); t++) begin
            for (int c = 0; c < 4; c++)
                if (wc[c] != 0 && t == int'(maxc - wc[c])) pwm[c] = 1'b1;
            @(posedge clk); #1;
        end
        pwm = '0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); @(negedge clk);
            if (lat < 0 && ch_update != 0) begin
                lat    = n;
                upd_at = ch_update;
            end
        end
        if (v.exp_upd != 0) check(lat == 4, {name, "_latency"}, lat, 4, 4);
        check(upd_at == v.exp_upd, {name, "_update"}, int'(upd_at), int'(v.exp_upd),
              int'(v.exp_upd));
        for (int c = 0; c < 4; c++)
            check_rng($sformatf("%s_val%0d", name, c), val_of(c), v.lo[c], v.hi[c]);
        check(ch_valid == v.exp_valid, {name, "_valid"}, int'(ch_valid), int'(v.exp_valid),
              int'(v.exp_valid));
        check(signal_lost == (v.exp_valid != 4'hF), {name, "_lost"}, int'(signal_lost),
              int'(v.exp_valid != 4'hF), int'(v.exp_valid != 4'hF));
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs [7];
        vec_t vfin;
        bit   bad;
        int   t0;
        int   n;

        vecs[0] = mk(0, 1500, 0, 0, 4'b0010, 4'b0010, 0, 0, 126, 128, 0, 0, 0, 0);
        vecs[1] = mk(0, 1500, 0, 0, 4'b0010, 4'b0010, 0, 0, 126, 128, 0, 0, 0, 0);
        vecs[2] = mk(2100, 0, 0, 0, 4'b0001, 4'b0011, 255, 255, 126, 128, 0, 0, 0, 0);
        vecs[3] = mk(900, 0, 0, 0, 4'b0001, 4'b0011, 0, 0, 126, 128, 0, 0, 0, 0);
        vecs[4] = mk(400, 0, 0, 0, 4'b0000, 4'b0011, 0, 0, 126, 128, 0, 0, 0, 0);
        vecs[5] = mk(1000, 1250, 1750, 2000, 4'b1111, 4'b1111,
                     0, 0, 62, 64, 190, 192, 254, 255);
        vecs[6] = mk(0, 0, 1500, 1250, 4'b1100, 4'b1111, 0, 0, 62, 64, 126, 128, 62, 64);
        vfin    = mk(0, 0, 0, 1500, 4'b1000, 4'b1000, 0, 0, 0, 0, 0, 0, 126, 128);

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(ch_val == '0, "reset_val", int'(ch_val != '0), 0, 0);
        check(ch_update == '0, "reset_update", int'(ch_update), 0, 0);
        check(ch_valid == '0, "reset_valid", int'(ch_valid), 0, 0);
        check(signal_lost == 1'b1, "reset_lost", int'(signal_lost), 1, 1);

        // No pulses for longer than the timeout: outputs stay at reset values.
        bad = 1'b0;
        repeat (11000) begin
            @(negedge clk);
            if (ch_val != '0 || ch_update != '0 || ch_valid != '0 || !signal_lost) bad = 1'b1;
        end
        check(!bad, "idle_outputs", int'(bad), 0, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Channel 2 (and 3) stop pulsing: ch_valid[2] must fall TMO us after its accept.
        t0 = last_up2;
        n  = 0;
        while (ch_valid[2] && n < 12000) begin
            @(negedge clk);
            n++;
        end
        check(!ch_valid[2], "timeout_ch2_falls", int'(ch_valid[2]), 0, 0);
        check_rng("timeout_ch2_cycles", cyc - t0, TMO * DIV - 4, TMO * DIV + 4);
        check(signal_lost == 1'b1, "timeout_lost", int'(signal_lost), 1, 1);
`ifdef RC_FAILSAFE_EN
        check(ch_update[2] == 1'b1, "timeout_ch2_update", int'(ch_update[2]), 1, 1);
        check_rng("timeout_ch2_val", val_of(2), 128, 128);
`else
        check(ch_update[2] == 1'b0, "timeout_ch2_update", int'(ch_update[2]), 0, 0);
        check_rng("timeout_ch2_val", val_of(2), 126, 128);
`endif

        // One-cycle reset in the middle of a channel 3 pulse.
        @(posedge clk); #1 pwm[3] = 1'b1;
        repeat (1000) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(ch_val == '0, "midreset_val", int'(ch_val != '0), 0, 0);
        check(ch_update == '0, "midreset_update", int'(ch_update), 0, 0);
        check(ch_valid == '0, "midreset_valid", int'(ch_valid), 0, 0);
        check(signal_lost == 1'b1, "midreset_lost", int'(signal_lost), 1, 1);
        repeat (1000) @(posedge clk);
        #1 pwm[3] = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ch_update != '0) bad = 1'b1;
        end
        check(!bad, "midreset_tail_no_update", int'(bad), 0, 0);
        repeat (10) @(posedge clk);
        #1;
        run_vec(vfin, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
